// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared states, widths and default commands for the DAC sequencer
package dac_seq_pkg;

  localparam int WORD_W  = 16;
  localparam int CMD_W   = 4;
  localparam int FIELD_W = WORD_W - CMD_W;

  localparam logic [CMD_W-1:0] DEF_CMD_A = 4'h3;
  localparam logic [CMD_W-1:0] DEF_CMD_B = 4'hB;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEL  = 3'd1;
  localparam logic [2:0] S_STRB = 3'd2;
  localparam logic [2:0] S_WLO  = 3'd3;
  localparam logic [2:0] S_WHI  = 3'd4;
  localparam logic [2:0] S_LDAC = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_SEL  = S_SEL,
    ST_STRB = S_STRB,
    ST_WLO  = S_WLO,
    ST_WHI  = S_WHI,
    ST_LDAC = S_LDAC,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/dac_word_fmt.sv
// rtl/dac_word_fmt.sv - combinational formatter building the 16-bit DAC command word
import dac_seq_pkg::*;

module dac_word_fmt #(
  parameter int DATA_W = 12
) (
  input  logic              sel_b,
  input  logic [CMD_W-1:0]  cmd_a,
  input  logic [CMD_W-1:0]  cmd_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [WORD_W-1:0] word
);

  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;

  // pick the channel's command nibble and sample, then pack {cmd, data}
  always_comb begin
    cmd  = sel_b ? cmd_b : cmd_a;
    data = sel_b ? data_b : data_a;
    word = {cmd, FIELD_W'(data)};
  end

endmodule

// File: rtl/dac_2ch_seq.sv
// rtl/dac_2ch_seq.sv - two-channel DAC update sequencer; DAC_SEQ_LDAC_EN adds the LDAC pulse
import dac_seq_pkg::*;

module dac_2ch_seq #(
  parameter int               DATA_W = 12,
  parameter logic [CMD_W-1:0] CMD_A  = DEF_CMD_A,
  parameter logic [CMD_W-1:0] CMD_B  = DEF_CMD_B,
  parameter int               TO_CYC = 4,
  parameter int               LDAC_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        ch_en_i,
  input  logic [DATA_W-1:0] ch_a_i,
  input  logic [DATA_W-1:0] ch_b_i,
  input  logic              eow_i,
  output logic              strw_o,
  output logic [WORD_W-1:0] word_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ldac_n_o
);

  localparam int               CNT_W    = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  state_t             state, state_n;
  logic [1:0]         pend;
  logic [DATA_W-1:0]  a_q, b_q;
  logic               cur_b;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  fmt_word;
  logic               accept, load_word, timeout, word_done;

  // channel A has priority, so B is selected only once A is no longer pending
  dac_word_fmt #(.DATA_W(DATA_W)) u_fmt (
    .sel_b  (~pend[0]),
    .cmd_a  (CMD_A),
    .cmd_b  (CMD_B),
    .data_a (a_q),
    .data_b (b_q),
    .word   (fmt_word)
  );

`ifdef DAC_SEQ_LDAC_EN
  localparam int                LCNT_W    = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LDAC_W - 1);
  logic [LCNT_W-1:0] lcnt;

  // count cycles spent in LDAC to size the load pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 lcnt <= '0;
    else if (state == ST_LDAC) lcnt <= lcnt + 1'b1;
    else                       lcnt <= '0;
  end

  assign ldac_n_o = (state != ST_LDAC);
`else
  assign ldac_n_o = 1'b0;
`endif

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // next-state decode and handshake strobes
  always_comb begin
    state_n   = state;
    strw_o    = 1'b0;
    accept    = 1'b0;
    load_word = 1'b0;
    timeout   = 1'b0;
    word_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_n = ST_SEL;
        end
      end
      ST_SEL: begin
        if (pend != 2'b00) begin
          load_word = 1'b1;
          state_n   = ST_STRB;
        end else begin
`ifdef DAC_SEQ_LDAC_EN
          state_n = ST_LDAC;
`else
          state_n = ST_DONE;
`endif
        end
      end
      ST_STRB: begin
        if (eow_i) begin
          strw_o  = 1'b1;
          state_n = ST_WLO;
        end
      end
      ST_WLO: begin
        if (!eow_i) begin
          state_n = ST_WHI;
        end else if (cnt == CNT_LAST) begin
          timeout = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_WHI: begin
        if (eow_i) begin
          word_done = 1'b1;
          state_n   = ST_SEL;
        end
      end
`ifdef DAC_SEQ_LDAC_EN
      ST_LDAC: begin
        if (lcnt == LCNT_LAST) state_n = ST_DONE;
      end
`endif
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // timeout counter: cycles spent in WLO waiting for the writer to go busy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        cnt <= '0;
    else if (state == ST_WLO && state_n == ST_WLO)    cnt <= cnt + 1'b1;
    else                                              cnt <= '0;
  end

  // request latches, pending mask, word register and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend   <= 2'b00;
      a_q    <= '0;
      b_q    <= '0;
      cur_b  <= 1'b0;
      word_o <= '0;
      err_o  <= 1'b0;
    end else begin
      if (accept) begin
        pend  <= ch_en_i;
        a_q   <= ch_a_i;
        b_q   <= ch_b_i;
        err_o <= 1'b0;
      end
      if (load_word) begin
        word_o <= fmt_word;
        cur_b  <= ~pend[0];
      end
      if (word_done) pend[cur_b] <= 1'b0;
      if (timeout) begin
        pend  <= 2'b00;
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_2ch_seq.sv
// tb/tb_dac_2ch_seq.sv - randomized self-checking bench for dac_2ch_seq with a behavioural SPI writer
`timescale 1ns/1ps

module tb_dac_2ch_seq;

  localparam int DATA_W = 12;
  localparam int TO_CYC = 4;
  localparam int LDAC_W = 2;
  localparam int WORD_CYC = 43;  // SEL..next SEL with a writer that stays busy for 40 cycles
`ifdef DAC_SEQ_LDAC_EN
  localparam int   LX        = LDAC_W;
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam int   LX        = 0;
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic              clk, rst_i, start_i, eow_i;
  logic [1:0]        ch_en_i;
  logic [DATA_W-1:0] ch_a_i, ch_b_i;
  logic              strw_o, busy_o, done_o, err_o, ldac_n_o;
  logic [15:0]       word_o;

  dac_2ch_seq #(.DATA_W(DATA_W), .CMD_A(4'h3), .CMD_B(4'hB), .TO_CYC(TO_CYC), .LDAC_W(LDAC_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ch_en_i(ch_en_i), .ch_a_i(ch_a_i),
    .ch_b_i(ch_b_i), .eow_i(eow_i), .strw_o(strw_o), .word_o(word_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .ldac_n_o(ldac_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int          cyc;
  logic [15:0] words[$];
  int          strw_cycs[$];
  int          rises[$];
  logic [15:0] exp_q[$];
  int          n_done, done_cyc, ldac_low;
  logic        busy_c1, err_c1, err_at_done, busy_after_done;
  int          w_timer, w_hold_until;
  bit          w_ignore;

  task automatic clear_mon();
    cyc = 0;
    words.delete(); strw_cycs.delete(); rises.delete();
    n_done = 0; done_cyc = -1; ldac_low = 0;
    busy_c1 = 1'bx; err_c1 = 1'bx; err_at_done = 1'bx; busy_after_done = 1'bx;
    w_timer = 0; w_hold_until = 0; w_ignore = 0;
  endtask

  // one clock: observe mid-cycle, advance the writer model, apply its eow just after the edge
  task automatic step();
    logic nxt;
    @(negedge clk);
    if (strw_o) begin words.push_back(word_o); strw_cycs.push_back(cyc); end
    if (done_o) begin n_done++; done_cyc = cyc; err_at_done = err_o; end
    if (cyc == 1) begin busy_c1 = busy_o; err_c1 = err_o; end
    if (n_done > 0 && cyc == done_cyc + 1) busy_after_done = busy_o;
    if (!ldac_n_o) ldac_low++;
    nxt = eow_i;
    if (strw_o && !w_ignore) begin
      nxt = 1'b0; w_timer = 40;
    end else if (w_timer > 0) begin
      w_timer--;
      if (w_timer == 0) begin nxt = 1'b1; rises.push_back(cyc + 1); end
    end
    if (cyc + 1 < w_hold_until) nxt = 1'b0;
    else if (w_hold_until > 0 && cyc + 1 == w_hold_until) begin nxt = 1'b1; rises.push_back(cyc + 1); end
    @(posedge clk); #1;
    cyc++;
    eow_i = nxt;
  endtask

  // reference: one word per enabled channel, A before B, {cmd, data}
  task automatic build_expect(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b);
    exp_q.delete();
    if (m[0]) exp_q.push_back({4'h3, a});
    if (m[1]) exp_q.push_back({4'hB, b});
  endtask

  task automatic run_txn(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b,
                         input int hold, input bit ignore, input int rs_cyc);
    clear_mon();
    w_hold_until = hold; w_ignore = ignore;
    ch_en_i = m; ch_a_i = a; ch_b_i = b; start_i = 1'b1;
    step();
    start_i = 1'b0;
    while (n_done == 0 && cyc < 300) begin
      if (cyc == rs_cyc) begin
        start_i = 1'b1; ch_en_i = 2'b11; ch_a_i = ~a; ch_b_i = ~b;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    start_i = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; eow_i = 1'b1; ch_en_i = 2'b00; ch_a_i = '0; ch_b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (strw_o !== 1'b0) $display("FAIL reset_strw: got %b want 0", strw_o); else n_pass++;
    n_total++; if (word_o !== 16'h0) $display("FAIL reset_word: got %h want 0000", word_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_total++; if (ldac_n_o !== LDAC_IDLE) $display("FAIL reset_ldac: got %b want %b", ldac_n_o, LDAC_IDLE); else n_pass++;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_both_channels();
    run_txn(2'b11, 12'h123, 12'hABC, 0, 0, -1);
    n_total++; if (busy_c1 !== 1'b1) $display("FAIL both_busy_c1: got %b want 1", busy_c1); else n_pass++;
    n_total++; if (words.size() != 2) $display("FAIL both_nstrw: got %0d want 2", words.size()); else n_pass++;
    if (words.size() >= 2) begin
      n_total++; if (words[0] !== 16'h3123) $display("FAIL both_word_a: got %h want 3123", words[0]); else n_pass++;
      n_total++; if (words[1] !== 16'hBABC) $display("FAIL both_word_b: got %h want BABC", words[1]); else n_pass++;
      n_total++; if (strw_cycs[0] != 2) $display("FAIL both_first_strw: got cycle %0d want 2", strw_cycs[0]); else n_pass++;
      if (rises.size() >= 1) begin
        n_total++; if (strw_cycs[1] != rises[0] + 2) $display("FAIL both_gap: got cycle %0d want %0d", strw_cycs[1], rises[0] + 2); else n_pass++;
      end
    end
    n_total++; if (n_done != 1) $display("FAIL both_ndone: got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc != 2 + 2*WORD_CYC + LX) $display("FAIL both_done_cyc: got %0d want %0d", done_cyc, 2 + 2*WORD_CYC + LX); else n_pass++;
    n_total++; if (err_at_done !== 1'b0) $display("FAIL both_err: got %b want 0", err_at_done); else n_pass++;
    n_total++; if (busy_after_done !== 1'b0) $display("FAIL both_busy_end: got %b want 0", busy_after_done); else n_pass++;
`ifdef DAC_SEQ_LDAC_EN
    n_total++; if (ldac_low != LDAC_W) $display("FAIL both_ldac_width: got %0d want %0d", ldac_low, LDAC_W); else n_pass++;
`endif
  endtask

  task automatic test_b_only();
    run_txn(2'b10, 12'h123, 12'hABC, 0, 0, -1);
    n_total++; if (words.size() != 1) $display("FAIL bonly_nstrw: got %0d want 1", words.size()); else n_pass++;
    if (words.size() >= 1) begin
      n_total++; if (words[0] !== 16'hBABC) $display("FAIL bonly_word: got %h want BABC", words[0]); else n_pass++;
    end
    n_total++; if (n_done != 1) $display("FAIL bonly_ndone: got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_empty_mask();
    run_txn(2'b00, 12'h555, 12'hAAA, 0, 0, -1);
    n_total++; if (words.size() != 0) $display("FAIL empty_nstrw: got %0d want 0", words.size()); else n_pass++;
    n_total++; if (done_cyc != 2 + LX) $display("FAIL empty_done_cyc: got %0d want %0d", done_cyc, 2 + LX); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL empty_ndone: got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [11:0] a;
    a = 12'($urandom);
    run_txn(2'b11, a, 12'hABC, 0, 1, -1);
    n_total++; if (words.size() != 1) $display("FAIL to_nstrw: got %0d want 1", words.size()); else n_pass++;
    if (words.size() >= 1) begin
      n_total++; if (words[0] !== {4'h3, a}) $display("FAIL to_word: got %h want %h", words[0], {4'h3, a}); else n_pass++;
    end
    n_total++; if (err_at_done !== 1'b1) $display("FAIL to_err: got %b want 1", err_at_done); else n_pass++;
    n_total++; if (done_cyc != 3 + TO_CYC) $display("FAIL to_done_cyc: got %0d want %0d", done_cyc, 3 + TO_CYC); else n_pass++;
    n_total++; if (err_o !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", err_o); else n_pass++;
`ifdef DAC_SEQ_LDAC_EN
    n_total++; if (ldac_low != 0) $display("FAIL to_ldac_skip: got %0d want 0", ldac_low); else n_pass++;
`endif
    run_txn(2'b00, 12'h0, 12'h0, 0, 0, -1);
    n_total++; if (err_c1 !== 1'b0) $display("FAIL to_err_clear: got %b want 0", err_c1); else n_pass++;
  endtask

  task automatic test_busy_writer();
    logic [11:0] a;
    a = 12'($urandom);
    eow_i = 1'b0;
    run_txn(2'b01, a, 12'h0, 7, 0, 12);
    n_total++; if (words.size() != 1) $display("FAIL busyw_nstrw: got %0d want 1", words.size()); else n_pass++;
    if (words.size() >= 1) begin
      n_total++; if (strw_cycs[0] != 7) $display("FAIL busyw_strw_cyc: got %0d want 7", strw_cycs[0]); else n_pass++;
      n_total++; if (words[0] !== {4'h3, a}) $display("FAIL busyw_word: got %h want %h", words[0], {4'h3, a}); else n_pass++;
    end
    n_total++; if (n_done != 1) $display("FAIL busyw_ndone: got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc != 7 + WORD_CYC + LX) $display("FAIL busyw_done_cyc: got %0d want %0d", done_cyc, 7 + WORD_CYC + LX); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0]  m;
    logic [11:0] a, b;
    for (int it = 0; it < 6; it++) begin
      m = 2'($urandom); a = 12'($urandom); b = 12'($urandom);
      build_expect(m, a, b);
      run_txn(m, a, b, 0, 0, -1);
      n_total++; if (words.size() != exp_q.size()) $display("FAIL rnd_nstrw[%0d]: got %0d want %0d", it, words.size(), exp_q.size()); else n_pass++;
      for (int k = 0; k < exp_q.size() && k < words.size(); k++) begin
        n_total++; if (words[k] !== exp_q[k]) $display("FAIL rnd_word[%0d.%0d]: got %h want %h", it, k, words[k], exp_q[k]); else n_pass++;
      end
      n_total++; if (done_cyc != 2 + exp_q.size()*WORD_CYC + LX) $display("FAIL rnd_done_cyc[%0d]: got %0d want %0d", it, done_cyc, 2 + exp_q.size()*WORD_CYC + LX); else n_pass++;
      n_total++; if (err_at_done !== 1'b0) $display("FAIL rnd_err[%0d]: got %b want 0", it, err_at_done); else n_pass++;
`ifdef DAC_SEQ_LDAC_EN
      n_total++; if (ldac_low != LDAC_W) $display("FAIL rnd_ldac[%0d]: got %0d want %0d", it, ldac_low, LDAC_W); else n_pass++;
`endif
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    ch_en_i = 2'b11; ch_a_i = 12'($urandom); ch_b_i = 12'($urandom); start_i = 1'b1;
    step();
    start_i = 1'b0;
    while (cyc < 10) step();
    #2 rst_i = 1'b1;
    #1;
    n_total++; if (busy_o !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (word_o !== 16'h0) $display("FAIL arst_word: got %h want 0000", word_o); else n_pass++;
    n_total++; if (strw_o !== 1'b0) $display("FAIL arst_strw: got %b want 0", strw_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL arst_done: got %b want 0", done_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL arst_err: got %b want 0", err_o); else n_pass++;
    n_total++; if (ldac_n_o !== LDAC_IDLE) $display("FAIL arst_ldac: got %b want %b", ldac_n_o, LDAC_IDLE); else n_pass++;
    @(posedge clk); #1;
    rst_i = 1'b0; eow_i = 1'b1; w_timer = 0;
    run_txn(2'b00, 12'h0, 12'h0, 0, 0, -1);
    n_total++; if (done_cyc != 2 + LX) $display("FAIL arst_idle_after: got done cycle %0d want %0d", done_cyc, 2 + LX); else n_pass++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_both_channels();
    test_b_only();
    test_empty_mask();
    test_timeout();
    test_busy_writer();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dac_2ch_seq.md
# dac_2ch_seq

Upstream sequencer for the two-channel DAC SPI write path. It accepts one update request carrying values for channels A and B. It formats each enabled channel into a 16-bit DAC command word and hands the words one at a time to the SPI write FSM using that FSM's start strobe and end-of-write handshake. It reports completion or a handshake fault to the controlling logic.

## Interface
Parameters:
- DATA_W, 12, DAC sample width.
- CMD_A, 4'h3, command/address nibble for channel A.
- CMD_B, 4'hB, command/address nibble for channel B.
- TO_CYC, 4, maximum clk_i cycles allowed between strw_o and eow_i going low.
- LDAC_W, 2, ldac_n_o low-pulse width in cycles (LDAC build only).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  update request; sampled only in IDLE.
- ch_en_i  in  2  channel mask, bit0 = A, bit1 = B; latched with start_i.
- ch_a_i  in  DATA_W  channel A value; latched with start_i.
- ch_b_i  in  DATA_W  channel B value; latched with start_i.
- eow_i  in  1  end-of-write from the SPI writer; high = writer idle.
- strw_o  out  1  start-write strobe to the SPI writer.
- word_o  out  16  word to the writer's shift register, {cmd[3:0], data[11:0]}.
- busy_o  out  1  high from the cycle after start_i is accepted until DONE is exited.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky handshake-timeout flag; cleared by the next accepted start_i.
- ldac_n_o  out  1  DAC load-DAC strobe, active-low.

## Operation
- States: IDLE, SEL, STRB, WLO, WHI, LDAC, DONE. Encoding is defined in the package.
- IDLE
  - On start_i: latch ch_a_i, ch_b_i and ch_en_i into data registers and a pending mask; clear err_o; go to SEL.
- SEL
  - Channel A pending: word_o <= {CMD_A, a}, go to STRB.
  - Else channel B pending: word_o <= {CMD_B, b}, go to STRB.
  - Else: go to LDAC (macro defined) or DONE.
  - Channel A is always written before channel B.
- STRB
  - strw_o = 1 combinationally only while eow_i = 1; then go to WLO.
  - While eow_i = 0 (writer still busy), stay in STRB with strw_o = 0.
- WLO
  - Wait for eow_i = 0; then go to WHI.
  - The timeout counter counts cycles spent in WLO. If TO_CYC cycles elapse with eow_i still high: set err_o, clear the whole pending mask, go to DONE. The remaining channel is not written and LDAC is skipped.
- WHI
  - Wait for eow_i = 1; then clear the current channel's pending bit and go to SEL.
  - WHI has no timeout.
- LDAC: ldac_n_o = 0 for LDAC_W cycles, then go to DONE.
- DONE: done_o = 1 for one cycle, go to IDLE.
- word_o is held stable from SEL until the next SEL. The writer loads it while eow_i is low.
- start_i outside IDLE is ignored, not queued.
- ch_en_i = 2'b00: SEL goes straight to DONE (or LDAC). No strw_o is issued.

## Timing
- Reset values: strw_o 0, word_o 0, busy_o 0, done_o 0, err_o 0, ldac_n_o 1 with the macro / 0 without. State is IDLE, pending mask 0, counter 0.
- Reset asserted mid-transaction aborts immediately to the reset values. The SPI writer shares rst_i.
- start_i high at cycle 0 in IDLE:
  - busy_o = 1 from cycle 1 (SEL).
  - The first strw_o can be high no earlier than cycle 2.
- strw_o is high for exactly one cycle per word. The writer drops eow_i the following cycle.
- After WHI sees eow_i = 1, the next strw_o comes 2 cycles later (SEL, then STRB).
- done_o is asserted 1 cycle after the final SEL, or LDAC_W + 1 cycles after it in the LDAC build. busy_o falls in the cycle after done_o.
- Counter width is clog2(TO_CYC + 1). Its value never exceeds TO_CYC.

## Configuration
- DAC_SEQ_LDAC_EN defined:
  - The LDAC state exists.
  - ldac_n_o idles high and pulses low for LDAC_W cycles after all pending words finish, so both channels update together.
- DAC_SEQ_LDAC_EN undefined:
  - The LDAC state and its counter are compiled out.
  - ldac_n_o is tied 0 (transparent DAC update). SEL goes directly to DONE.

## Structure
- Package dac_seq_pkg holds:
  - the state localparams;
  - the word width (16) and command-field width (4);
  - the default CMD_A and CMD_B values.
- Sub-module dac_word_fmt: combinational formatter from {channel select, cmd, data} to the 16-bit word. Its output is registered in dac_2ch_seq at SEL.
- The timeout counter and LDAC counter stay inline.

## Test plan
The bench uses a behavioural writer model that drops eow_i 1 cycle after strw_o and raises it again 40 cycles later.
- Both channels: ch_en_i = 2'b11, a = 12'h123, b = 12'hABC, start_i pulse.
  - word_o = 16'h3123 at the first strw_o and 16'hBABC at the second.
  - Exactly 2 strw_o pulses, then one done_o pulse; err_o = 0.
- Channel B only: ch_en_i = 2'b10.
  - A single strw_o with word_o = 16'hBABC; done_o follows.
- Empty mask: ch_en_i = 2'b00.
  - No strw_o; done_o at cycle 2 (no macro) or cycle 2 + LDAC_W (macro).
- Timeout: the writer model ignores strw_o.
  - err_o is set after 4 cycles in WLO; done_o follows; the channel-B word is never strobed.
  - The next start_i clears err_o.
- Busy writer, then restart:
  - eow_i is held low when STRB is entered. strw_o must stay 0 until eow_i rises, then pulse once.
  - start_i pulsed during WHI is ignored.
- Async reset mid-transfer: rst_i asserted in WHI.
  - All outputs return to their reset values within the same cycle, and state is IDLE.
  - The LDAC build checks that ldac_n_o is low for exactly LDAC_W cycles per completed update.
